fourier_frame_ctrl: RTL
=======================

Name: fourier_frame_ctrl

Overview:
Frame sequencer wrapped around the fourier core (fourier_srg / fourier_rns port set: addr, x, operation, y_re, y_im, done).
- Upstream: accepts a valid/ready sample stream.
- Core side: drives the core's operation/addr protocol through the load (01), process (10) and read-out (11) phases.
- Downstream: streams the N complex results out on a registered valid/ready interface.
- Replaces the hand-written sequencing that benches currently do around the core.

Parameters:
N, 10, samples per frame and bins per frame (2..256).
W, 32, width of sample and result words.
TIMEOUT_CYCLES, 1024, maximum PROC duration; used only with the optional feature.

Ports:
clk  in  1  clock, all logic on posedge.
reset_n  in  1  asynchronous, active-low reset.
s_valid  in  1  input sample valid.
s_ready  out  1  input sample accepted when s_valid&s_ready.
s_data  in  W  input sample.
f_operation  out  2  core op: 00 idle, 01 write x, 10 process, 11 read.
f_addr  out  32  core sample/bin index, zero-extended k.
f_x  out  W  core sample data.
f_y_re  in  W  core result real, combinationally valid for current f_addr while op=11.
f_y_im  in  W  core result imaginary, same timing as f_y_re.
f_done  in  1  core processing complete.
m_valid  out  1  output bin valid.
m_ready  in  1  downstream accepts on m_valid&m_ready.
m_re  out  W  registered bin real.
m_im  out  W  registered bin imaginary.
m_index  out  8  bin number of m_re/m_im.
m_last  out  1  high with bin N-1.
busy  out  1  state != IDLE.
err  out  1  one-cycle timeout pulse; constant 0 without the optional feature.

Behaviour:
- Reset (any time, including mid-frame) returns state to IDLE.
  - Reset values: k=0, f_operation=00, f_addr=0, f_x=0, s_ready=0, m_valid=0, m_re=0, m_im=0, m_index=0, m_last=0, busy=0, err=0.
  - Partial frame is discarded; the core is not reset by this block.
- FSM states: IDLE, LOAD, PROC, DRAIN, FLUSH.
- IDLE:
  - s_ready=0, op=00.
  - s_valid=1 -> LOAD next cycle; k=0.
- LOAD:
  - s_ready=1; f_x=s_data, f_addr=k combinationally.
  - f_operation=01 only in handshake cycles, else 00, so stalls never write the core.
  - Each handshake: k++.
  - Handshake at k=N-1 -> PROC, k=0.
- PROC:
  - op=10, s_ready=0, held until f_done=1 is sampled.
  - f_done=1 -> DRAIN next cycle.
  - f_done already high on PROC entry -> PROC lasts exactly 1 cycle.
- DRAIN:
  - op=11, f_addr=k.
  - When (!m_valid | m_ready): capture m_re=f_y_re, m_im=f_y_im, m_index=k, m_last=(k==N-1); set m_valid=1; k++.
  - Capture at k=N-1 -> FLUSH.
  - First m_valid rises 1 cycle after DRAIN entry. With m_ready held high, throughput is 1 bin/cycle.
- FLUSH:
  - op=00.
  - When the last bin handshakes: m_valid=0 -> IDLE.
- Output hold: m_* are stable while m_valid & !m_ready.
  - m_valid drops only on a handshake with no new capture.
- Back-to-back frames: minimum gap is 1 IDLE cycle between the last output handshake and the next s_ready.
- Counter k is clog2(N)+1 bits; no wrap beyond N-1; f_addr never exceeds N-1.
- Frame latency, no stalls: N load cycles + PROC length + 1 + N output cycles.

Optional Feature:
- Macro: FOURIER_FRAME_CTRL_TIMEOUT_EN.
- Defined:
  - A PROC cycle counter clears on PROC entry.
  - If it reaches TIMEOUT_CYCLES without f_done, err pulses 1 cycle and state -> IDLE with op=00; no outputs are produced for that frame.
- Undefined: no counter, err tied 0, PROC waits indefinitely.

Decomposition:
- Shared package fourier_pkg holds:
  - fourier_op_t enum: OP_IDLE=2'b00, OP_LOAD=2'b01, OP_PROC=2'b10, OP_READ=2'b11. The core and this block both use it.
  - frame_state_t enum.
  - Default N.
- One sub-module: fourier_out_reg, the W+W+8+1 output register with valid/ready hold logic.
- FSM, counter and timeout stay in the top module.

Test Plan:
- Reset, then samples 0..9 with s_valid constant and m_ready=1, against fourier_srg N=10:
  - expect 10 op=01 writes at addr 0..9;
  - then op=10 until done;
  - then bins 0..9 out with bin0 re=45, im=0, and m_last only on index 9.
- Input bubbles: s_valid toggled 1,0,1,0:
  - f_operation=00 on every bubble cycle;
  - exactly 10 writes;
  - core contents match the no-bubble run.
- Output backpressure: m_ready low 3 cycles at index 4:
  - m_re, m_im, m_index stay at index 4 values;
  - f_addr stays 5;
  - no bin is lost or duplicated.
- Two frames back-to-back (0..9, then all 1s):
  - second frame bin0 re=10, im=0;
  - exactly 1 IDLE cycle between frames.
- reset_n asserted during DRAIN at index 6:
  - all outputs 0 at the same edge;
  - next frame completes normally from addr 0.
- FOURIER_FRAME_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, f_done stuck 0:
  - err pulses once 16 cycles after PROC entry;
  - busy=0 next cycle;
  - m_valid never rises.

Source files
------------

// File: rtl/fourier_pkg.sv
// Shared types for the fourier core and its frame sequencer.
package fourier_pkg;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_LOAD = 2'b01,
      OP_PROC = 2'b10,
      OP_READ = 2'b11
   } fourier_op_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_PROC  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_FLUSH = 3'd4
   } frame_state_t;

   localparam int FOURIER_N_DEFAULT = 10;
   localparam int FOURIER_W_DEFAULT = 32;

   // One spare bit so the sample/bin index can hold N itself.
   function automatic int k_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/fourier_frame_ctrl_if.sv
// Sample stream, core-side and result stream signals of the frame sequencer.
interface fourier_frame_ctrl_if #(
   parameter int W = 32
) ();

   logic                      s_valid;
   logic                      s_ready;
   logic [W-1:0]              s_data;

   fourier_pkg::fourier_op_t  f_operation;
   logic [31:0]               f_addr;
   logic [W-1:0]              f_x;
   logic [W-1:0]              f_y_re;
   logic [W-1:0]              f_y_im;
   logic                      f_done;

   logic                      m_valid;
   logic                      m_ready;
   logic [W-1:0]              m_re;
   logic [W-1:0]              m_im;
   logic [7:0]                m_index;
   logic                      m_last;

   modport master (
      input  s_valid, s_data, f_y_re, f_y_im, f_done, m_ready,
      output s_ready, f_operation, f_addr, f_x,
             m_valid, m_re, m_im, m_index, m_last
   );

   modport slave (
      output s_valid, s_data, f_y_re, f_y_im, f_done, m_ready,
      input  s_ready, f_operation, f_addr, f_x,
             m_valid, m_re, m_im, m_index, m_last
   );

endinterface

// File: rtl/fourier_out_reg.sv
// Registered result slot with valid/ready hold: contents only change on a load.
module fourier_out_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] d_re,
   input  logic [W-1:0] d_im,
   input  logic [7:0]   d_index,
   input  logic         d_last,
   input  logic         m_ready,
   output logic         can_load,
   output logic         m_valid,
   output logic [W-1:0] m_re,
   output logic [W-1:0] m_im,
   output logic [7:0]   m_index,
   output logic         m_last
);

   assign can_load = !m_valid || m_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_valid <= 1'b0;
         m_re    <= '0;
         m_im    <= '0;
         m_index <= '0;
         m_last  <= 1'b0;
      end else if (load && can_load) begin
         m_valid <= 1'b1;
         m_re    <= d_re;
         m_im    <= d_im;
         m_index <= d_index;
         m_last  <= d_last;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fourier_frame_ctrl.sv
// Frame sequencer around the fourier core: load N samples, process, stream N bins.
// Optional PROC watchdog is built when FOURIER_FRAME_CTRL_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for first s_valid of a frame
// LOAD  | writing samples into the core, one per handshake
// PROC  | core processing, waiting for f_done
// DRAIN | reading bins from the core into the output register
// FLUSH | last bin captured, waiting for its handshake
module fourier_frame_ctrl
   import fourier_pkg::*;
#(
   parameter int N              = FOURIER_N_DEFAULT,
   parameter int W              = FOURIER_W_DEFAULT,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   fourier_frame_ctrl_if.master bus,
   output logic                 busy,
   output logic                 err
);

   localparam int            KW     = k_width(N);
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   if (N < 2 || N > 256 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("fourier_frame_ctrl: parameter out of range");
   end

   frame_state_t  state, state_nxt;
   logic [KW-1:0] k, k_nxt;
   logic          cap;
   logic          can_load;
   logic          out_hs;
   logic          timeout_hit;

   assign out_hs = bus.m_valid && bus.m_ready;
   assign busy   = (state != ST_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         k     <= '0;
      end else begin
         state <= state_nxt;
         k     <= k_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      k_nxt           = k;
      cap             = 1'b0;
      bus.s_ready     = 1'b0;
      bus.f_operation = OP_IDLE;
      bus.f_addr      = '0;
      bus.f_x         = '0;
      case (state)
         ST_IDLE: begin
            k_nxt = '0;
            if (bus.s_valid) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            bus.s_ready = 1'b1;
            bus.f_x     = bus.s_data;
            bus.f_addr  = 32'(k);
            // Only handshake cycles write, so upstream stalls leave the core untouched.
            if (bus.s_valid) begin
               bus.f_operation = OP_LOAD;
               if (k == K_LAST) begin
                  k_nxt     = '0;
                  state_nxt = ST_PROC;
               end else begin
                  k_nxt = k + KW'(1);
               end
            end
         end
         ST_PROC: begin
            bus.f_operation = OP_PROC;
            if (bus.f_done) begin
               k_nxt     = '0;
               state_nxt = ST_DRAIN;
            end else if (timeout_hit) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            bus.f_operation = OP_READ;
            bus.f_addr      = 32'(k);
            cap             = can_load;
            if (cap) begin
               if (k == K_LAST) begin
                  k_nxt     = '0;
                  state_nxt = ST_FLUSH;
               end else begin
                  k_nxt = k + KW'(1);
               end
            end
         end
         ST_FLUSH: begin
            if (out_hs) state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            k_nxt     = '0;
         end
      endcase
   end

   fourier_out_reg #(.W(W)) u_out_reg (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (cap),
      .d_re     (bus.f_y_re),
      .d_im     (bus.f_y_im),
      .d_index  (8'(k)),
      .d_last   (k == K_LAST),
      .m_ready  (bus.m_ready),
      .can_load (can_load),
      .m_valid  (bus.m_valid),
      .m_re     (bus.m_re),
      .m_im     (bus.m_im),
      .m_index  (bus.m_index),
      .m_last   (bus.m_last)
   );

`ifdef FOURIER_FRAME_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] to_cnt;

   // Reloaded outside PROC so it starts fresh on every PROC entry; terminal count is 0.
   assign timeout_hit = (state == ST_PROC) && !bus.f_done && (to_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt <= '0;
         err    <= 1'b0;
      end else begin
         err <= timeout_hit;
         if (state != ST_PROC) to_cnt <= TW'(TIMEOUT_CYCLES - 1);
         else if (to_cnt != '0) to_cnt <= to_cnt - TW'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

endmodule
